// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller and its decoder.
package ssd_pkg;

  typedef enum logic {
    BLANK   = 1'b0,
    DISPLAY = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low anode level for position pos: low only when lit and selected.
  function automatic logic an_level(input logic lit, input int unsigned sel,
                                    input int unsigned pos);
    return !(lit && (sel == pos));
  endfunction

endpackage

// File: rtl/ssd_driver.sv
// Hex nibble to active-low seven-segment decoder, segment order {a,b,c,d,e,f,g}.
module ssd_driver (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    unique case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with dead-time blanking,
// frame-synchronous value commit and optional leading-zero suppression.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         dp_mask,
  output logic [6:0]                    out_ssd,
  output logic [NUM_DIGITS-1:0]         out_an,
  output logic                          out_dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] BL_LAST  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_e                 state, nstate;
  logic [CNT_W-1:0]            cnt, ncnt;
  logic [IDX_W-1:0]            nidx;
  logic [4*NUM_DIGITS-1:0]     pending, display, ndisp;
  logic [NUM_DIGITS-1:0]       pending_dp, display_dp, ndp;
  logic                        nft, commit;
  logic [3:0]                  nibble;
  logic [6:0]                  dec_seg;
  logic [NUM_DIGITS-1:0]       lz_zero;
  logic                        lz_acc, lz_blank;
  logic [6:0]                  ssd_n;
  logic [NUM_DIGITS-1:0]       an_n;
  logic                        dp_n;

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nidx   = digit_idx;
    nft    = 1'b0;
    commit = 1'b0;
    if (!enable) begin
      nstate = BLANK;
      ncnt   = '0;
    end else begin
      unique case (state)
        BLANK: begin
          if (cnt == BL_LAST) begin
            nstate = DISPLAY;
            ncnt   = '0;
            commit = (digit_idx == '0);
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        DISPLAY: begin
          if (cnt == RD_LAST) begin
            nstate = BLANK;
            ncnt   = '0;
            nidx   = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            nft    = (digit_idx == IDX_LAST);
          end else begin
            ncnt = cnt + 1'b1;
          end
        end
        default: nstate = BLANK;
      endcase
    end
  end

  // A load landing on the commit edge bypasses pending so the newest value wins.
  always_comb begin
    ndisp = display;
    ndp   = display_dp;
    if (commit) begin
      ndisp = load ? value : pending;
      ndp   = load ? dp_mask : pending_dp;
    end
  end

  // Outputs are built from next-state values so they switch on the state-change edge.
  always_comb begin
    nibble = ndisp[{nidx, 2'b00} +: 4];
    lz_acc = 1'b1;
    lz_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_acc     = lz_acc & (ndisp[4*i +: 4] == 4'h0);
      lz_zero[i] = lz_acc;
    end
    lz_blank = (LZ_BLANK != 0) && (nidx != '0) && lz_zero[nidx];
    ssd_n = ((nstate == DISPLAY) && !lz_blank) ? dec_seg : SEG_OFF;
    dp_n  = (nstate == DISPLAY) ? ~ndp[nidx] : 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_n[i] = an_level(nstate == DISPLAY, int'(nidx), i);
    end
  end

  ssd_driver u_dec (
    .hex (nibble),
    .seg (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      digit_idx  <= '0;
      frame_tick <= 1'b0;
      out_ssd    <= SEG_OFF;
      out_an     <= '1;
      out_dp     <= 1'b1;
      pending    <= '0;
      pending_dp <= '0;
      display    <= '0;
      display_dp <= '0;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      digit_idx  <= nidx;
      frame_tick <= nft;
      out_ssd    <= ssd_n;
      out_an     <= an_n;
      out_dp     <= dp_n;
      display    <= ndisp;
      display_dp <= ndp;
      if (load) begin
        pending    <= value;
        pending_dp <= dp_mask;
      end
    end
  end

endmodule
